// File: rtl/lock_key_sequencer_pkg.sv
// Shared definitions for the lock key sequencer.
//   - default core widths and settle time
//   - controller state encoding
//   - even-parity helper used when checking a freshly shifted key
package lock_pkg;
  localparam int KEY_W      = 32;
  localparam int PI_W       = 36;
  localparam int PO_W       = 7;
  localparam int SETTLE_CYC = 4;

  typedef enum logic [2:0] {
    IDLE, SHIFT, CHECK, APPLY, ACTIVE, QWAIT, RESP, ERROR
  } state_e;

  // Callers zero-extend their key into v; zero padding does not change XOR.
  function automatic logic parity_even(input logic [63:0] v, input logic p);
    return ~((^v) ^ p);
  endfunction
endpackage

// File: rtl/lock_key_sequencer_if.sv
// Key-delivery, query and response signals between a host and the sequencer.
//   slave  : the sequencer side (drives key/core/response outputs)
//   master : the host side (drives load, serial key, query, core_po, r_ready)
interface lock_key_sequencer_if #(
  parameter int KEY_W = lock_pkg::KEY_W,
  parameter int PI_W  = lock_pkg::PI_W,
  parameter int PO_W  = lock_pkg::PO_W
);
  logic             load_start;
  logic             key_sdi;
  logic             key_sdv;
  logic             key_busy;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             err;
  logic             q_valid;
  logic             q_ready;
  logic [PI_W-1:0]  q_pi;
  logic [PI_W-1:0]  core_pi;
  logic [PO_W-1:0]  core_po;
  logic             r_valid;
  logic             r_ready;
  logic [PO_W-1:0]  r_po;

  modport slave (
    input  load_start, key_sdi, key_sdv, q_valid, q_pi, core_po, r_ready,
    output key_busy, key_out, key_valid, err, q_ready, core_pi, r_valid, r_po
  );

  modport master (
    output load_start, key_sdi, key_sdv, q_valid, q_pi, core_po, r_ready,
    input  key_busy, key_out, key_valid, err, q_ready, core_pi, r_valid, r_po
  );
endinterface

// File: rtl/lock_key_sequencer_key_shift_rx.sv
// Serial key receiver: LSB-first shadow register, bit counter and parity bit.
//   clk, rst  : clock, async active-high reset
//   clr       : restart the load from bit 0 (clears shadow and counter)
//   en        : receiver is in its shift phase
//   sdi, sdv  : serial data bit and its valid strobe
//   shadow    : bits received so far
//   last      : the parity bit is being consumed this cycle
//   parity_ok : shadow plus captured parity bit has even parity
module key_shift_rx
  import lock_pkg::*;
#(
  parameter int KEY_W = lock_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sdi,
  input  logic             sdv,
  output logic [KEY_W-1:0] shadow,
  output logic             last,
  output logic             parity_ok
);
  localparam int CW = $clog2(KEY_W + 1);

  logic [CW-1:0] cnt;
  logic          par;

  assign last      = en & sdv & (cnt == CW'(KEY_W));
  assign parity_ok = parity_even(64'(shadow), par);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= '0;
      par    <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      shadow <= '0;
      par    <= 1'b0;
    end else if (en && sdv) begin
      if (cnt == CW'(KEY_W)) begin
        par <= sdi;
      end else begin
        // OR in a shifted bit: avoids indexing shadow with a counter one bit wider.
        shadow <= shadow | (KEY_W'(sdi) << cnt);
        cnt    <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/lock_key_sequencer.sv
// Key load / settle / query controller for a logic-locked combinational core.
//   clk, rst : clock, async active-high reset
//   bus      : key delivery, query, core drive and response signals
// A key is shifted in, parity-checked, committed atomically to key_out, and
// given SETTLE_CYC cycles before queries are accepted. Each query drives
// core_pi, waits SETTLE_CYC cycles, then captures core_po into r_po.
module lock_key_sequencer
  import lock_pkg::*;
#(
  parameter int KEY_W      = lock_pkg::KEY_W,
  parameter int SETTLE_CYC = lock_pkg::SETTLE_CYC
) (
  input logic                 clk,
  input logic                 rst,
  lock_key_sequencer_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_e           state, state_n;
  logic [SW-1:0]    settle;
  logic             load_acc, hs, rx_last, rx_ok;
  logic [KEY_W-1:0] shadow;

  assign load_acc     = bus.load_start & (state inside {IDLE, ERROR, ACTIVE, SHIFT});
  // load_start wins over a simultaneous query
  assign bus.q_ready  = (state == ACTIVE) & ~bus.load_start;
  assign hs           = bus.q_valid & bus.q_ready;
  assign bus.key_busy = (state == SHIFT);

  key_shift_rx #(.KEY_W(KEY_W)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .clr       (load_acc),
    .en        (state == SHIFT),
    .sdi       (bus.key_sdi),
    .sdv       (bus.key_sdv),
    .shadow    (shadow),
    .last      (rx_last),
    .parity_ok (rx_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (load_acc) begin
      state_n = SHIFT;
    end else begin
      case (state)
        SHIFT:   if (rx_last) state_n = CHECK;
        CHECK:   state_n = rx_ok ? APPLY : ERROR;
        APPLY:   if (settle == '0) state_n = ACTIVE;
        ACTIVE:  if (hs) state_n = QWAIT;
        QWAIT:   if (settle == '0) state_n = RESP;
        RESP:    if (bus.r_ready) state_n = ACTIVE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle        <= '0;
      bus.key_out   <= '0;
      bus.key_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.core_pi   <= '0;
      bus.r_po      <= '0;
      bus.r_valid   <= 1'b0;
    end else if (load_acc) begin
      bus.err       <= 1'b0;
      bus.key_valid <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          if (rx_ok) begin
            bus.key_out <= shadow;
            settle      <= SW'(SETTLE_CYC);
          end else begin
            bus.err <= 1'b1;
          end
        end
        APPLY: begin
          if (settle == '0) bus.key_valid <= 1'b1;
          else              settle        <= settle - 1'b1;
        end
        ACTIVE: begin
          if (hs) begin
            bus.core_pi <= bus.q_pi;
            settle      <= SW'(SETTLE_CYC);
          end
        end
        QWAIT: begin
          if (settle == '0) begin
            bus.r_po    <= bus.core_po;
            bus.r_valid <= 1'b1;
          end else begin
            settle <= settle - 1'b1;
          end
        end
        RESP: if (bus.r_ready) bus.r_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_key_sequencer.sv
// Self-checking bench for lock_key_sequencer: directed key/query sequences,
// a table of key loads, and a randomized phase against a behavioural model.
module tb_lock_key_sequencer;
  localparam int SET = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub_mode = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  lock_key_sequencer_if bus ();

  lock_key_sequencer #(.SETTLE_CYC(SET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Core stub: constant 7'h55, or a fixed function of the applied pattern.
  function automatic logic [6:0] core_fn(input logic [35:0] pi);
    return pi[6:0] ^ pi[35:29];
  endfunction
  assign bus.core_po = stub_mode ? core_fn(bus.core_pi) : 7'h55;

  typedef struct {
    logic [31:0] key;
    logic        par;
    logic        exp_err;
  } load_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " key_out"},   bus.key_out,   0);
    chk({tag, " key_valid"}, bus.key_valid, 0);
    chk({tag, " err"},       bus.err,       0);
    chk({tag, " key_busy"},  bus.key_busy,  0);
    chk({tag, " r_valid"},   bus.r_valid,   0);
    chk({tag, " core_pi"},   bus.core_pi,   0);
    chk({tag, " r_po"},      bus.r_po,      0);
    chk({tag, " q_ready"},   bus.q_ready,   0);
  endtask

  // Waits for key_valid (use_r=0) or r_valid (use_r=1); expects first high at negedge n.
  task automatic rise(input string nm, input bit use_r, input int n);
    int first = 0;
    for (int k = 1; k <= n + 3 && first == 0; k++) begin
      @(negedge clk);
      if ((use_r ? bus.r_valid : bus.key_valid) === 1'b1) first = k;
    end
    chk(nm, first, n);
  endtask

  // Shift {par,key}; returns one negedge after the CHECK edge.
  task automatic load_key(input logic [31:0] key, input logic par, input bit do_start,
                          input bit gaps, input int junk);
    logic [32:0] v;
    v = {par, key};
    if (do_start) begin
      bus.load_start = 1'b1; @(negedge clk); bus.load_start = 1'b0;
    end
    for (int j = 0; j < junk; j++) begin
      bus.key_sdv = 1'b1; bus.key_sdi = 1'($urandom()); @(negedge clk); bus.key_sdv = 1'b0;
    end
    if (junk > 0) begin
      bus.load_start = 1'b1; @(negedge clk); bus.load_start = 1'b0;
    end
    for (int i = 0; i <= 32; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.key_sdv = 1'b1; bus.key_sdi = v[i]; @(negedge clk); bus.key_sdv = 1'b0;
    end
    @(negedge clk);
  endtask

  // One query from ACTIVE; holds r_ready low for hold cycles before consuming.
  task automatic do_query(input logic [35:0] pi, input logic [6:0] exp_po, input int hold);
    bit stable;
    bus.q_valid = 1'b1; bus.q_pi = pi; #1;
    chk("q_ready in ACTIVE", bus.q_ready, 1);
    @(negedge clk); bus.q_valid = 1'b0;
    chk("core_pi after handshake", bus.core_pi, pi);
    rise("r_valid latency", 1'b1, SET + 1);
    chk("r_po", bus.r_po, exp_po);
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (bus.r_valid !== 1'b1 || bus.r_po !== exp_po || bus.q_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk("resp held while r_ready=0", stable, 1);
    bus.r_ready = 1'b1; @(negedge clk); bus.r_ready = 1'b0;
    chk("r_valid drop after r_ready", bus.r_valid, 0);
    chk("q_ready after response", bus.q_ready, 1);
  endtask

  initial begin
    load_vec_t   tbl[8];
    logic [31:0] exp_key;
    logic [31:0] m_key;
    bit          m_valid;

    bus.load_start = 0; bus.key_sdi = 0; bus.key_sdv = 0;
    bus.q_valid = 0; bus.q_pi = '0; bus.r_ready = 0;

    tbl[0] = '{32'hA5A50F0F, 1'b0, 1'b0};
    tbl[1] = '{32'hA5A50F0F, 1'b1, 1'b1};
    tbl[2] = '{32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[3] = '{32'h00000001, 1'b0, 1'b1};
    tbl[4] = '{32'h00000001, 1'b1, 1'b0};
    tbl[5] = '{32'h00000007, 1'b0, 1'b1};
    tbl[6] = '{32'h80000000, 1'b1, 1'b0};
    tbl[7] = '{32'h00000000, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Bad parity right after reset: nothing commits, queries blocked.
    load_key(32'hA5A50F0F, 1'b1, 1, 0, 0);
    chk("bad parity err", bus.err, 1);
    chk("bad parity key_out", bus.key_out, 0);
    chk("bad parity key_valid", bus.key_valid, 0);
    bus.q_valid = 1'b1; #1;
    chk("ERROR q_ready", bus.q_ready, 0);
    bus.q_valid = 1'b0;
    bus.load_start = 1'b1; @(negedge clk); bus.load_start = 1'b0;
    chk("reload clears err", bus.err, 0);
    chk("reload key_busy", bus.key_busy, 1);

    // Good key: commit then settle.
    load_key(32'hA5A50F0F, 1'b0, 0, 0, 0);
    chk("good key_out", bus.key_out, 32'hA5A50F0F);
    chk("good err", bus.err, 0);
    rise("key_valid latency", 1'b0, SET + 1);

    // Query with constant stub and a 10-cycle back-pressured response.
    do_query(36'h123456789, 7'h55, 10);

    // load_start beats a simultaneous query.
    bus.load_start = 1'b1; bus.q_valid = 1'b1; bus.q_pi = 36'hABCDEF012; #1;
    chk("load_start vs q_valid q_ready", bus.q_ready, 0);
    @(negedge clk); bus.load_start = 1'b0; bus.q_valid = 1'b0;
    chk("preempt key_busy", bus.key_busy, 1);
    chk("preempt key_valid", bus.key_valid, 0);
    chk("preempt core_pi unchanged", bus.core_pi, 36'h123456789);
    load_key(32'h0F0F0F0F, 1'b0, 0, 0, 0);
    chk("preempt reload key_out", bus.key_out, 32'h0F0F0F0F);
    rise("preempt key_valid", 1'b0, SET + 1);

    // Table of loads.
    exp_key = bus.key_out === 32'h0F0F0F0F ? 32'h0F0F0F0F : 32'h0F0F0F0F;
    for (int i = 0; i < 8; i++) begin
      load_key(tbl[i].key, tbl[i].par, 1, 0, 0);
      if (!tbl[i].exp_err) exp_key = tbl[i].key;
      chk($sformatf("tbl%0d err", i), bus.err, tbl[i].exp_err);
      chk($sformatf("tbl%0d key_out", i), bus.key_out, exp_key);
      if (tbl[i].exp_err) chk($sformatf("tbl%0d key_valid", i), bus.key_valid, 0);
      else                rise($sformatf("tbl%0d key_valid", i), 1'b0, SET + 1);
    end

    // Async reset after 17 of 33 bits.
    bus.load_start = 1'b1; @(negedge clk); bus.load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.key_sdv = 1'b1; bus.key_sdi = 1'b1; @(negedge clk);
    end
    bus.key_sdv = 1'b0;
    rst = 1'b1; #1;
    chk_reset("mid-shift reset");
    @(negedge clk); rst = 1'b0; @(negedge clk);
    load_key(32'hFFFFFFFF, 1'b0, 1, 0, 0);
    chk("post-reset key_out", bus.key_out, 32'hFFFFFFFF);
    rise("post-reset key_valid", 1'b0, SET + 1);

    // Restart mid-shift with gaps: only the second key counts.
    load_key(32'h3C3C_5A5A, 1'b0, 1, 1, 11);
    chk("restart key_out", bus.key_out, 32'h3C3C5A5A);
    chk("restart err", bus.err, 0);
    rise("restart key_valid", 1'b0, SET + 1);

    // Randomized phase against a behavioural model.
    stub_mode = 1'b1;
    m_key = 32'h3C3C5A5A;
    m_valid = 1'b1;
    for (int it = 0; it < 16; it++) begin
      if (!m_valid || $urandom_range(0, 2) == 0) begin
        logic [31:0] k;
        logic        p;
        bit          ok;
        k  = $urandom();
        p  = 1'($urandom());
        ok = ((^k) ^ p) == 1'b0;
        load_key(k, p, 1, 1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0);
        if (ok) m_key = k;
        chk($sformatf("rnd%0d err", it), bus.err, !ok);
        chk($sformatf("rnd%0d key_out", it), bus.key_out, m_key);
        if (ok) rise($sformatf("rnd%0d key_valid", it), 1'b0, SET + 1);
        else    chk($sformatf("rnd%0d key_valid", it), bus.key_valid, 0);
        m_valid = ok;
      end else begin
        logic [35:0] pi;
        pi = 36'({4'($urandom()), $urandom()});
        do_query(pi, core_fn(pi), $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
